// File: rtl/serial_addsub_n.sv
// -----------------------------------------------------------------------------
// serial_addsub_n
// Bit-serial adder/subtractor. Two WIDTH-bit operands are loaded in parallel
// and folded through one full-adder slice, LSB first, one bit per enabled
// clock. The carry between bit slices is held in a register. The result is
// returned in parallel, together with carry-out and signed-overflow flags.
//
// Optional feature (compile-time macro):
//   SERIAL_ADDSUB_SAT_EN  - when defined, a signed overflow saturates sum to
//                           the most positive or most negative value.
//                           overflow and cout still report the raw condition.
//
// Parameters:
//   WIDTH     operand/result width, 2..32 (default 8)
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   start     in   load operands and begin (accepted in IDLE or DONE)
//   sub       in   0 = a+b, 1 = a-b (sampled with start)
//   a, b      in   operands (sampled with start)
//   shift_en  in   advance one bit this cycle; 0 stalls SHIFT
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse, result valid
//   sum       out  result, held until the next accepted start
//   cout      out  add: carry out of MSB; sub: 1 = no borrow
//   overflow  out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Only WIDTH-1 partial bits need storing: the final bit is combined with
  // them directly on the edge that writes sum.
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_s;
  logic             w_c_next;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_sum_next;

  // ---------------------------------------------------------------------------
  // Full-adder slice on the current LSBs
  // ---------------------------------------------------------------------------
  assign w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c_next = (r_a_sr[0] & r_b_sr[0]) |
                    (r_a_sr[0] & r_carry)   |
                    (r_b_sr[0] & r_carry);

  assign w_step   = (r_state == ST_SHIFT) && shift_en;
  assign w_last   = w_step && (r_cnt == CW'(WIDTH - 1));

  // New bit enters at the top; after WIDTH steps the LSB of the result has
  // travelled down to bit 0.
  assign w_final  = {w_s, r_res};

  // On the MSB slice, carry in differs from carry out exactly on overflow.
  assign w_ovf    = r_carry ^ w_c_next;

`ifdef SERIAL_ADDSUB_SAT_EN
  // Overflow can only occur when both operand MSBs agree, so A's MSB alone
  // gives the direction (0: positive overflow, 1: negative overflow).
  always_comb begin
    w_sum_next = w_final;
    if (w_ovf) begin
      w_sum_next = r_a_sr[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_sum_next = w_final;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // start is deliberately not looked at here: the operation in flight
        // always runs to completion.
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a_sr  <= a;
        // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
        r_b_sr  <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (w_step) begin
        r_a_sr  <= r_a_sr >> 1;
        r_b_sr  <= r_b_sr >> 1;
        r_carry <= w_c_next;
        r_cnt   <= r_cnt + CW'(1);
        r_res   <= w_final[WIDTH-1:1];
        if (w_last) begin
          r_sum  <= w_sum_next;
          r_cout <= w_c_next;
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  assign busy     = (r_state == ST_SHIFT);
  assign done     = (r_state == ST_DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
